// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and frame constants for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through synchronous FIFO; data_o shows the head entry, 0 when empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // a full FIFO frees the head slot in the same cycle, so push-with-pop succeeds
    assign do_push = push_i && (!full_o || do_pop);
    assign count_d = (do_push && !do_pop) ? count_q + 1'b1 :
                     (!do_push && do_pop) ? count_q - 1'b1 : count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q    <= do_pop ? rd_q + 1'b1 : rd_q;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver (8E1 with UART_RX_PARITY_EN) feeding a byte FIFO.
// Synchronizer, FSM, cycle/bit counters and shift register live here; storage is uart_rx_fifo.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 67_500_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_TIME - 1);

    uart_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic          meta_q, rx_s;
    logic          armed_q, armed_d;
    logic          sym_tick, stop_smp, par_bad, push, fifo_full, fifo_empty, pop;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign sym_tick = cnt_q == SYM_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            meta_q  <= serial_in;
            rx_s    <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        armed_d = armed_q | rx_s;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // armed blocks a held-low break line from looking like a new start bit
                if (armed_q && !rx_s) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: if (cnt_q == SMP_LAST) begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (sym_tick) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sym_tick) begin
                cnt_d   = '0;
                par_d   = rx_s;
                state_d = STOP;
            end
`endif
            STOP: if (sym_tick) begin
                state_d = IDLE;
                if (!rx_s) armed_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stop_smp   = state_q == STOP && sym_tick;
`ifdef UART_RX_PARITY_EN
        par_bad    = par_q != ^shift_q;
`else
        par_bad    = 1'b0;
`endif
        push       = stop_smp && rx_s && !par_bad;
        frame_err  = stop_smp && !rx_s;
        parity_err = stop_smp && rx_s && par_bad;
        pop        = data_out_valid && data_out_ready;
        overflow   = push && fifo_full && !pop;
    end

    assign data_out_valid = !fifo_empty;

    uart_rx_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (shift_q),
        .data_o  (data_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
endmodule
